stream_wr: RTL

FX3 slave-FIFO write master: moves words from a local show-ahead FIFO to the USB host over the GPIF-II slave-FIFO bus.
- Operates in the host-bound direction, selected by DATA_DIR=1, with the FIFO address at thread 0 (A1=0, A0=0).
- Shares the slave-FIFO pins with the existing host-to-FPGA read engine; DATA_DIR arbitrates between the two blocks.
- Bursts are bounded by BURST_LEN and by the FX3 partial flag (watermark).

---
 rtl/stream_wr_if.sv | 26 ++
 rtl/stream_wr.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/stream_wr_if.sv
// GPIF-II slave-FIFO bus bundle between the FPGA write master and the FX3.
// The master modport is the FPGA side; the slave modport models the FX3.
interface stream_wr_if #(
  parameter int DATA_W = 32
);
  logic              FLAGA;
  logic              FLAGB;
  logic [DATA_W-1:0] DQ;
  logic              SLCS;
  logic              SLWR;
  logic              SLOE;
  logic              SLRD;
  logic              A1;
  logic              A0;
  logic              PKTEND;

  modport master (
    input  FLAGA, FLAGB,
    output DQ, SLCS, SLWR, SLOE, SLRD, A1, A0, PKTEND
  );

  modport slave (
    output FLAGA, FLAGB,
    input  DQ, SLCS, SLWR, SLOE, SLRD, A1, A0, PKTEND
  );
endinterface

// File: rtl/stream_wr.sv
// FX3 slave-FIFO write master: streams a show-ahead FIFO to thread 0 in bounded bursts.
// Define STREAM_WR_PKTEND_EN to commit short packets after PKT_TMO source-idle cycles.
module stream_wr #(
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 256,
  parameter int CNT_W     = 9,
  parameter int GAP_CYC   = 6,
  parameter int PKT_TMO   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              DATA_DIR,
  stream_wr_if.master       bus,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_empty,
  output logic              src_rd,
  output logic [CNT_W-1:0]  usb_wr_cnt,
  output logic [2:0]        usb_wr_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEL0     = 3'd1,
    S_SEL1     = 3'd2,
    S_WAIT_RDY = 3'd3,
    S_WRITE    = 3'd4,
    S_GAP      = 3'd5
  } state_t;

  if (((2 ** CNT_W) <= BURST_LEN) || (GAP_CYC < 2) || (PKT_TMO < 1)) begin : g_param_check
    $error("stream_wr: illegal parameter combination");
  end

  // The IDLE cycle also drives SLCS high, so GAP itself lasts GAP_CYC-1 cycles.
  localparam int                 GAP_W      = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYC - 2);
  localparam logic [CNT_W-1:0]   BURST_MAX  = CNT_W'(BURST_LEN);

  state_t              state_q;
  logic                slcs_q;
  logic                slwr_q;
  logic                a1_q;
  logic                a0_q;
  logic [DATA_W-1:0]   dq_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                flagb1_q;
  logic [GAP_W-1:0]    gap_q;

  logic                in_write;
  logic                w_en;
  logic                commit;
  logic                burst_end;

`ifdef STREAM_WR_PKTEND_EN
  localparam int                IDLE_W  = $clog2(PKT_TMO + 1);
  localparam logic [IDLE_W-1:0] TMO_VAL = IDLE_W'(PKT_TMO);

  logic                pktend_q;
  logic [IDLE_W-1:0]   idle_q;
  logic [IDLE_W-1:0]   idle_d;
`endif

  always_comb begin
    in_write  = DATA_DIR & (state_q == S_WRITE);
    commit    = 1'b0;
`ifdef STREAM_WR_PKTEND_EN
    commit    = in_write & (cnt_q != '0) & (idle_q == TMO_VAL);
`endif
    w_en      = in_write & flagb1_q & ~src_empty & (cnt_q < BURST_MAX) & ~commit;
    cnt_d     = w_en ? (cnt_q + CNT_W'(1)) : cnt_q;
    // Count limit is checked on the post-write value so the last write and GAP coincide.
    burst_end = (cnt_d >= BURST_MAX) | ~flagb1_q | commit;
  end

`ifdef STREAM_WR_PKTEND_EN
  always_comb begin
    idle_d = idle_q;
    if (!in_write || w_en || commit) begin
      idle_d = '0;
    end else if (src_empty && (cnt_q != '0)) begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      slcs_q   <= 1'b1;
      slwr_q   <= 1'b1;
      a1_q     <= 1'b1;
      a0_q     <= 1'b1;
      dq_q     <= '0;
      cnt_q    <= '0;
      flagb1_q <= 1'b1;
      gap_q    <= '0;
`ifdef STREAM_WR_PKTEND_EN
      pktend_q <= 1'b1;
`endif
    end else begin
      slcs_q   <= 1'b1;
      slwr_q   <= 1'b1;
      flagb1_q <= bus.FLAGB;
`ifdef STREAM_WR_PKTEND_EN
      pktend_q <= 1'b1;
`endif
      if (!DATA_DIR) begin
        // Bus handed to the read engine: release it and drop any burst in progress.
        state_q <= S_IDLE;
        a1_q    <= 1'b1;
        a0_q    <= 1'b1;
        cnt_q   <= '0;
        gap_q   <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            a1_q    <= 1'b0;
            a0_q    <= 1'b0;
            cnt_q   <= '0;
            gap_q   <= '0;
            state_q <= S_SEL0;
          end
          S_SEL0: begin
            slcs_q  <= 1'b0;
            state_q <= S_SEL1;
          end
          S_SEL1: begin
            slcs_q  <= 1'b0;
            state_q <= S_WAIT_RDY;
          end
          S_WAIT_RDY: begin
            slcs_q <= 1'b0;
            if (bus.FLAGA) begin
              state_q <= S_WRITE;
            end
          end
          S_WRITE: begin
            slcs_q <= 1'b0;
            cnt_q  <= cnt_d;
            if (w_en) begin
              slwr_q <= 1'b0;
              dq_q   <= src_data;
            end
`ifdef STREAM_WR_PKTEND_EN
            if (commit) begin
              pktend_q <= 1'b0;
            end
`endif
            if (burst_end) begin
              state_q <= S_GAP;
            end
          end
          S_GAP: begin
            if (gap_q == GAP_LAST) begin
              gap_q   <= '0;
              state_q <= S_IDLE;
            end else begin
              gap_q <= gap_q + GAP_W'(1);
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign src_rd       = w_en;
  assign usb_wr_cnt   = cnt_q;
  assign usb_wr_state = state_q;

  assign bus.DQ   = dq_q;
  assign bus.SLCS = slcs_q;
  assign bus.SLWR = slwr_q;
  assign bus.SLOE = 1'b1;
  assign bus.SLRD = 1'b1;
  assign bus.A1   = a1_q;
  assign bus.A0   = a0_q;
`ifdef STREAM_WR_PKTEND_EN
  assign bus.PKTEND = pktend_q;
`else
  assign bus.PKTEND = 1'b1;
`endif

endmodule
